// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register sitting directly after the control decoder.
//   Captures the decoded control word, register read data, immediate, PC and
//   register indices, and presents them to EX one cycle later. Detects a
//   load-use dependency against the load currently in EX, asks IF/ID to hold
//   (stall_o), and drops a bubble into EX. Control bits of bubbles and of
//   invalid ID slots are forced to zero so decoder don't-cares never reach EX.
//
//   Optional feature macro: LOAD_USE_HAZARD_EN
//     defined   : load-use detection and stall active
//     undefined : no hazard detection, stall_o tied low (flush still bubbles)
//
// Ports
//   Clk, Reset               clock, synchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_reg2loc               1 = second source is the Rt (id_rd) field
//   id_alusrc .. id_aluop    decoder control word
//   id_pc, id_rdata1/2, id_imm   DATA_W data from ID
//   id_rn, id_rm, id_rd      REG_AW register indices
//   flush                    branch taken downstream; kill the ID instruction
//   stall_o                  combinational hold request for PC and IF/ID
//   ex_valid, ex_<ctrl>, ex_<data>, ex_<index>   registered EX-side copies
// ---------------------------------------------------------------------------
// State table (per EX slot)
//   SLOT_EMPTY | bubble or invalid instruction in EX, controls all zero
//   SLOT_FULL  | real instruction in EX; if it is a load, hazard re-evaluated
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic              id_reg2loc,
    input  logic              id_alusrc,
    input  logic              id_mem2reg,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_branch,
    input  logic              id_uncond,
    input  logic [3:0]        id_aluop,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall_o,
    output logic              ex_valid,
    output logic              ex_alusrc,
    output logic              ex_mem2reg,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_branch,
    output logic              ex_uncond,
    output logic [3:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rn,
    output logic [REG_AW-1:0] ex_rm,
    output logic [REG_AW-1:0] ex_rd
);

    typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_FULL = 1'b1} slot_e;

    // control word layout: {alusrc, mem2reg, regwrite, memread, memwrite,
    //                       branch, uncond, aluop[3:0]}
    localparam int CTRL_W      = 11;
    localparam int MEMREAD_BIT = 7;

    slot_e              slot_q, slot_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [DATA_W-1:0]  rdata2_q, rdata2_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [REG_AW-1:0]  rn_q, rn_d;
    logic [REG_AW-1:0]  rm_q, rm_d;
    logic [REG_AW-1:0]  rd_q, rd_d;

    logic [CTRL_W-1:0]  id_ctrl;
    logic               haz;

    assign id_ctrl = {id_alusrc, id_mem2reg, id_regwrite, id_memread,
                      id_memwrite, id_branch, id_uncond, id_aluop};

`ifdef LOAD_USE_HAZARD_EN
    logic [REG_AW-1:0] src2;

    // Only a clean 1 selects Rt; an unknown reg2loc falls back to Rm.
    assign src2 = (id_reg2loc === 1'b1) ? id_rd : id_rm;

    // The zero register (all-ones index) is never a real producer.
    assign haz = id_valid && (slot_q == SLOT_FULL) && ctrl_q[MEMREAD_BIT]
              && (rd_q != {REG_AW{1'b1}})
              && ((id_rn == rd_q) || (src2 == rd_q));
`else
    logic unused_reg2loc;

    assign unused_reg2loc = id_reg2loc;
    assign haz            = 1'b0;
`endif

    assign stall_o = haz && !flush && !Reset;

    always_comb begin
        slot_d   = slot_q;
        ctrl_d   = ctrl_q;
        pc_d     = pc_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        rn_d     = rn_q;
        rm_d     = rm_q;
        rd_d     = rd_q;
        if (flush || haz) begin
            // Bubble: data fields are don't-care, so they simply hold.
            slot_d = SLOT_EMPTY;
            ctrl_d = '0;
        end else begin
            slot_d   = id_valid ? SLOT_FULL : SLOT_EMPTY;
            ctrl_d   = id_valid ? id_ctrl : '0;
            pc_d     = id_pc;
            rdata1_d = id_rdata1;
            rdata2_d = id_rdata2;
            imm_d    = id_imm;
            rn_d     = id_rn;
            rm_d     = id_rm;
            rd_d     = id_rd;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            slot_q   <= SLOT_EMPTY;
            ctrl_q   <= '0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            rd_q     <= '0;
        end else begin
            slot_q   <= slot_d;
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            rd_q     <= rd_d;
        end
    end

    assign ex_valid = (slot_q == SLOT_FULL);
    assign {ex_alusrc, ex_mem2reg, ex_regwrite, ex_memread,
            ex_memwrite, ex_branch, ex_uncond, ex_aluop} = ctrl_q;
    assign ex_pc     = pc_q;
    assign ex_rdata1 = rdata1_q;
    assign ex_rdata2 = rdata2_q;
    assign ex_imm    = imm_q;
    assign ex_rn     = rn_q;
    assign ex_rm     = rm_q;
    assign ex_rd     = rd_q;

endmodule
